// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch controller: f3Br funct3 codes, FSM states, BHT counter values.
package branch_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RESOLVE  = 2'd1,
        REDIRECT = 2'd2,
        FLUSH    = 2'd3
    } bc_state_e;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    // Codes 010/011 are not branch encodings.
    function automatic logic f3_defined(input logic [2:0] f3);
        return f3[2:1] != 2'b01;
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Execute-stage branch interface: op handshake, resolution, fetch redirect, flush and BHT lookup.
interface branch_ctrl_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_funct3;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic            in_pred_taken;
    logic            res_valid;
    logic            res_taken;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush;
    logic [XLEN-1:0] lk_pc;
    logic            lk_taken;

    modport master (
        output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken,
        output redirect_ready, lk_pc,
        input  in_ready, res_valid, res_taken, redirect_valid, redirect_pc, flush, lk_taken
    );

    modport slave (
        input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm, in_pred_taken,
        input  redirect_ready, lk_pc,
        output in_ready, res_valid, res_taken, redirect_valid, redirect_pc, flush, lk_taken
    );

endinterface

// File: rtl/branch_ctrl_branch.sv
// Combinational branch comparator: evaluates the f3Br condition on rs1/rs2 when branch is set.
module branch_ctrl_branch
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic                   branch,
    input  logic [2:0]             funct3,
    input  logic signed [XLEN-1:0] rs1,
    input  logic signed [XLEN-1:0] rs2,
    output logic                   taken
);

    always_comb begin
        taken = 1'b0;
        if (branch) begin
            case (funct3)
                F3_BEQ:  taken = (rs1 == rs2);
                F3_BNE:  taken = (rs1 != rs2);
                F3_BLT:  taken = (rs1 < rs2);
                F3_BGE:  taken = (rs1 >= rs2);
                F3_BLTU: taken = ($unsigned(rs1) < $unsigned(rs2));
                F3_BGEU: taken = ($unsigned(rs1) >= $unsigned(rs2));
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution sequencer: IDLE -> RESOLVE -> (REDIRECT -> FLUSH ->) IDLE.
// Define BRANCH_PREDICT_EN to build the 2-bit BHT behind lk_pc/lk_taken.
module branch_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    branch_ctrl_if.slave bus
);

    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    bc_state_e              state;
    logic [CNT_W-1:0]       flush_cnt;
    logic [XLEN-1:0]        redirect_pc_q;
    logic [2:0]             funct3_p1;
    logic signed [XLEN-1:0] rs1_p1;
    logic signed [XLEN-1:0] rs2_p1;
    logic [XLEN-1:0]        pc_p1;
    logic [XLEN-1:0]        imm_p1;
    logic                   pred_p1;
    logic                   taken;
    logic [XLEN-1:0]        target;
    logic [XLEN-1:0]        fallthrough;

    // Stage p1: operands captured on accept; data only, so no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.in_valid) begin
            funct3_p1 <= bus.in_funct3;
            rs1_p1    <= bus.in_rs1;
            rs2_p1    <= bus.in_rs2;
            pc_p1     <= bus.in_pc;
            imm_p1    <= bus.in_imm;
            pred_p1   <= bus.in_pred_taken;
        end
    end

    branch_ctrl_branch #(.XLEN(XLEN)) u_branch (
        .branch (1'b1),
        .funct3 (funct3_p1),
        .rs1    (rs1_p1),
        .rs2    (rs2_p1),
        .taken  (taken)
    );

    assign target      = pc_p1 + imm_p1;
    assign fallthrough = pc_p1 + XLEN'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            flush_cnt     <= '0;
            redirect_pc_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) state <= RESOLVE;
                end
                RESOLVE: begin
                    if (taken != pred_p1) begin
                        redirect_pc_q <= taken ? target : fallthrough;
                        state         <= REDIRECT;
                    end else begin
                        state <= IDLE;
                    end
                end
                REDIRECT: begin
                    if (bus.redirect_ready) begin
                        flush_cnt <= CNT_W'(FLUSH_CYCLES);
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == CNT_W'(1)) begin
                        flush_cnt <= '0;
                        state     <= IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign bus.in_ready       = (state == IDLE);
    assign bus.res_valid      = (state == RESOLVE);
    assign bus.res_taken      = (state == RESOLVE) && taken;
    assign bus.redirect_valid = (state == REDIRECT);
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush          = (state == FLUSH);

`ifdef BRANCH_PREDICT_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == ST) ? ST : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == SNT) ? SNT : c - 2'd1;
    endfunction

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] lk_idx;

    assign upd_idx = pc_p1[IDX_W+1:2];
    assign lk_idx  = bus.lk_pc[IDX_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= WNT;
        end else if (state == RESOLVE && f3_defined(funct3_p1)) begin
            bht[upd_idx] <= taken ? sat_inc(bht[upd_idx]) : sat_dec(bht[upd_idx]);
        end
    end

    // Read of the pre-update array gives the old value on a same-index collision.
    assign bus.lk_taken = bht[lk_idx][1];
`else
    assign bus.lk_taken = 1'b0;
`endif

endmodule
